// File: rtl/fifo_wr_ctrl.sv
// Write-domain side of the async FIFO. It accepts a valid/ready stream, drives the memory write port,
// synchronises the read Gray pointer, and reports full, almost-full, occupancy and overflow status.
module fifo_wr_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int AFULL_LVL = 14
) (
    input  logic              clk_wr,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_din,
    output logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wr_ptr_bin;
    logic [PW-1:0] ptr_bin_nxt;
    logic [PW-1:0] ptr_gray_nxt;
    logic [PW-1:0] rd_s1;
    logic [PW-1:0] rd_s2;
    logic [PW-1:0] rd_sync_bin;
    logic [PW-1:0] count_nxt;
    logic          full_nxt;
    logic          afull_nxt;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wr_en      = wr_req && !full;
    assign wr_ready   = !full;
    assign write_data = wr_din;
    assign write_addr = wr_ptr_bin[ADDR_W-1:0];

    // Status is computed from the post-write pointer so full asserts on the edge that fills the last slot.
    always_comb begin
        ptr_bin_nxt  = wr_ptr_bin + {{(PW-1){1'b0}}, wr_en};
        ptr_gray_nxt = ptr_bin_nxt ^ (ptr_bin_nxt >> 1);
        rd_sync_bin  = gray2bin(rd_s2);
        full_nxt     = (ptr_gray_nxt == {~rd_s2[PW-1:PW-2], rd_s2[PW-3:0]});
        count_nxt    = ptr_bin_nxt - rd_sync_bin;
        afull_nxt    = (count_nxt >= PW'(AFULL_LVL));
    end

    // Plain two-flop chain: any logic between the stages would defeat metastability settling.
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1 <= '0;
            rd_s2 <= '0;
        end else begin
            // NOTE: non-blocking assignments let rd_s2 take the old rd_s1, forming a real two-stage chain.
            rd_s1 <= rd_ptr_gray;
            rd_s2 <= rd_s1;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr_bin  <= ptr_bin_nxt;
            wr_ptr_gray <= ptr_gray_nxt;
            full        <= full_nxt;
            almost_full <= afull_nxt;
            wr_count    <= count_nxt;
            if (wr_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
